pcie_app_rst_sched: RTL and testbench

//  Sequences per-client application resets behind the PCIe HIP reset block (pld_clk domain).

---
 rtl/pcie_rst_pkg.sv | 22 ++
 rtl/pcie_rst_step_timer.sv | 27 ++
 rtl/pcie_app_rst_sched.sv | 179 +++++++++++++++++
 tb/tb_pcie_app_rst_sched.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_rst_pkg.sv
// Shared definitions for the PCIe application reset scheduler: sequencer states,
// the LTSSM L0 code and a small helper for sizing the shared step timer.
package pcie_rst_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RELEASE = 3'd1,
        ST_RUN     = 3'd2,
        ST_QUIESCE = 3'd3,
        ST_ASSERT  = 3'd4,
        ST_HOLD    = 3'd5
    } seq_state_t;

    localparam logic [4:0] LTSSM_L0 = 5'h0F;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pcie_rst_step_timer.sv
// Saturating load/enable down-counter; expired is high while the count sits at zero.
module pcie_rst_step_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/pcie_app_rst_sched.sv
// Per-client application reset sequencer behind the PCIe HIP: staged release once the
// link is usable, quiesce then reverse-order reassert on link loss or soft reset.
module pcie_app_rst_sched
    import pcie_rst_pkg::*;
#(
    parameter int N_CLIENTS = 4,
    parameter int GAP_CYC   = 16,
    parameter int QTO_CYC   = 4096,
    parameter int HOLD_CYC  = 64
) (
    input  logic                 pld_clk,
    input  logic                 crst,
    input  logic                 app_rstn,
    input  logic                 dl_up,
    input  logic [4:0]           ltssm,
    input  logic                 sw_rst_req,
    input  logic [N_CLIENTS-1:0] quiesce_ack,
    output logic [N_CLIENTS-1:0] client_rstn,
    output logic [N_CLIENTS-1:0] quiesce_req,
    output logic                 ready,
    output logic                 qto_err,
    output logic [2:0]           seq_state
);

    localparam int CW = $clog2(max3(GAP_CYC, QTO_CYC, HOLD_CYC)) + 1;
    localparam int IW = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;

    localparam logic [CW-1:0] GAP_LD  = CW'(GAP_CYC - 1);
    localparam logic [CW-1:0] QTO_LD  = CW'(QTO_CYC - 1);
    localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYC - 1);
    localparam logic [IW-1:0] LAST    = IW'(N_CLIENTS - 1);

    seq_state_t      state;
    logic [IW-1:0]   idx;
    logic            link_ok;
    logic            emerg;
    logic            all_ack;
    logic            expired;
    logic            tmr_load;
    logic            tmr_en;
    logic [CW-1:0]   tmr_val;

    assign emerg     = !app_rstn && (state != ST_IDLE) && (state != ST_HOLD);
    assign all_ack   = &quiesce_ack;
    assign seq_state = state;

    // The timer is preloaded in the cycle a timed state is entered, so each state
    // sees its first expiry exactly GAP/QTO/HOLD cycles after entry.
    always_comb begin
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
        tmr_val  = GAP_LD;
        if (emerg) begin
            tmr_load = 1'b1;
            tmr_val  = HOLD_LD;
        end else begin
            case (state)
                ST_IDLE: tmr_load = 1'b1;
                ST_RELEASE: begin
                    tmr_en   = 1'b1;
                    tmr_load = !link_ok || expired;
                end
                ST_RUN: begin
                    tmr_load = 1'b1;
                    tmr_val  = QTO_LD;
                end
                ST_QUIESCE: begin
                    tmr_en   = 1'b1;
                    tmr_load = all_ack || expired;
                end
                ST_ASSERT: begin
                    tmr_en   = 1'b1;
                    tmr_load = expired;
                    tmr_val  = (idx == '0) ? HOLD_LD : GAP_LD;
                end
                ST_HOLD: tmr_en = 1'b1;
                default: begin
                    tmr_load = 1'b1;
                    tmr_val  = HOLD_LD;
                end
            endcase
        end
    end

    pcie_rst_step_timer #(.W(CW)) u_timer (
        .clk      (pld_clk),
        .rst      (crst),
        .load     (tmr_load),
        .en       (tmr_en),
        .load_val (tmr_val),
        .expired  (expired)
    );

    always_ff @(posedge pld_clk or posedge crst) begin
        if (crst) begin
            state       <= ST_IDLE;
            idx         <= '0;
            link_ok     <= 1'b0;
            client_rstn <= '0;
            quiesce_req <= '0;
            ready       <= 1'b0;
            qto_err     <= 1'b0;
        end else begin
            link_ok <= app_rstn && dl_up && (ltssm == LTSSM_L0);
            if (emerg) begin
                state       <= ST_HOLD;
                idx         <= '0;
                client_rstn <= '0;
                quiesce_req <= '0;
                ready       <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (link_ok) begin
                            state <= ST_RELEASE;
                            idx   <= '0;
                        end
                    end
                    ST_RELEASE: begin
                        if (!link_ok) begin
                            state <= ST_ASSERT;
                            idx   <= LAST;
                        end else if (expired) begin
                            client_rstn[idx] <= 1'b1;
                            if (idx == LAST) begin
                                state <= ST_RUN;
                                ready <= 1'b1;
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end
                    end
                    ST_RUN: begin
                        if (sw_rst_req || !link_ok) begin
                            state       <= ST_QUIESCE;
                            ready       <= 1'b0;
                            quiesce_req <= '1;
                        end
                    end
                    ST_QUIESCE: begin
                        // A simultaneous ack and timeout counts as drained, not as an error.
                        if (all_ack) begin
                            state <= ST_ASSERT;
                            idx   <= LAST;
                        end else if (expired) begin
                            qto_err <= 1'b1;
                            state   <= ST_ASSERT;
                            idx     <= LAST;
                        end
                    end
                    ST_ASSERT: begin
                        if (expired) begin
                            client_rstn[idx] <= 1'b0;
                            if (idx == '0) begin
                                state       <= ST_HOLD;
                                quiesce_req <= '0;
                            end else begin
                                idx <= idx - 1'b1;
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (expired) begin
                            state <= ST_IDLE;
                        end
                    end
                    default: begin
                        state       <= ST_HOLD;
                        idx         <= '0;
                        client_rstn <= '0;
                        quiesce_req <= '0;
                        ready       <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pcie_app_rst_sched.sv
// Scoreboard bench for pcie_app_rst_sched: expected client_rstn edges are queued with
// their cycle numbers when stimulus is applied and popped whenever the outputs change.
module tb_pcie_app_rst_sched;
    import pcie_rst_pkg::*;

    localparam int N = 4;

    logic         pld_clk = 1'b0;
    logic         crst;
    logic         app_rstn;
    logic         dl_up;
    logic [4:0]   ltssm;
    logic         sw_rst_req;
    logic [N-1:0] quiesce_ack;
    logic [N-1:0] client_rstn;
    logic [N-1:0] quiesce_req;
    logic         ready;
    logic         qto_err;
    logic [2:0]   seq_state;

    typedef struct packed {
        int unsigned cyc;
        logic [N-1:0] rstn;
    } ev_t;

    ev_t          sb[$];
    int unsigned  cyc = 0;
    int           total = 0;
    int           bad = 0;
    logic [N-1:0] prev_rstn = '0;

    pcie_app_rst_sched #(
        .N_CLIENTS (N),
        .GAP_CYC   (16),
        .QTO_CYC   (4096),
        .HOLD_CYC  (64)
    ) dut (
        .pld_clk     (pld_clk),
        .crst        (crst),
        .app_rstn    (app_rstn),
        .dl_up       (dl_up),
        .ltssm       (ltssm),
        .sw_rst_req  (sw_rst_req),
        .quiesce_ack (quiesce_ack),
        .client_rstn (client_rstn),
        .quiesce_req (quiesce_req),
        .ready       (ready),
        .qto_err     (qto_err),
        .seq_state   (seq_state)
    );

    always #5 pld_clk = ~pld_clk;
    always @(posedge pld_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_ev(input int unsigned t, input logic [N-1:0] r);
        ev_t e;
        e.cyc  = t;
        e.rstn = r;
        sb.push_back(e);
    endtask

    // Releases land GAP cycles apart, the first one GAP cycles after RELEASE entry.
    task automatic push_release(input int unsigned entry);
        for (int k = 1; k <= N; k++) push_ev(entry + 16 * k, N'((1 << k) - 1));
    endtask

    task automatic push_assert(input int unsigned entry);
        for (int k = 1; k <= N; k++) push_ev(entry + 16 * k, N'(4'b1111 >> k));
    endtask

    task automatic wait_cyc(input int unsigned t);
        while (cyc < t) @(negedge pld_clk);
    endtask

    always @(negedge pld_clk) begin : mon
        ev_t e;
        if (client_rstn !== prev_rstn) begin
            if (sb.size() == 0) begin
                check("rstn_unexpected", 32'(client_rstn), 32'(prev_rstn));
            end else begin
                e = sb.pop_front();
                check("rstn_val", 32'(client_rstn), 32'(e.rstn));
                check("rstn_cyc", cyc, e.cyc);
            end
            prev_rstn = client_rstn;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned c;
        crst = 1'b1; app_rstn = 1'b1; dl_up = 1'b0; ltssm = 5'h00;
        sw_rst_req = 1'b0; quiesce_ack = '0;
        repeat (3) @(negedge pld_clk);
        check("rst_rstn", 32'(client_rstn), 0);
        check("rst_qreq", 32'(quiesce_req), 0);
        check("rst_ready", 32'(ready), 0);
        check("rst_qto", 32'(qto_err), 0);
        check("rst_state", 32'(seq_state), ST_IDLE);
        crst = 1'b0;

        // Link up but LTSSM not in L0: nothing may be released.
        dl_up = 1'b1; ltssm = 5'h10;
        c = cyc;
        wait_cyc(c + 40);
        check("t5_state", 32'(seq_state), ST_IDLE);
        check("t5_ready", 32'(ready), 0);
        check("t5_rstn", 32'(client_rstn), 0);

        // Power-up release sequence.
        ltssm = LTSSM_L0;
        c = cyc;
        push_release(c + 2);
        wait_cyc(c + 2);
        check("t1_state_rel", 32'(seq_state), ST_RELEASE);
        wait_cyc(c + 65);
        check("t1_ready_early", 32'(ready), 0);
        wait_cyc(c + 66);
        check("t1_ready", 32'(ready), 1);
        check("t1_state_run", 32'(seq_state), ST_RUN);

        // Soft reset: quiesce, reverse assert, hold, re-release.
        c = cyc;
        sw_rst_req = 1'b1;
        @(negedge pld_clk);
        sw_rst_req = 1'b0;
        check("t2_state_q", 32'(seq_state), ST_QUIESCE);
        check("t2_qreq", 32'(quiesce_req), 32'hF);
        check("t2_ready_drop", 32'(ready), 0);
        wait_cyc(c + 11);
        check("t2_still_q", 32'(seq_state), ST_QUIESCE);
        quiesce_ack = '1;
        push_assert(c + 12);
        wait_cyc(c + 12);
        check("t2_state_as", 32'(seq_state), ST_ASSERT);
        wait_cyc(c + 75);
        check("t2_qreq_held", 32'(quiesce_req), 32'hF);
        wait_cyc(c + 76);
        check("t2_state_hold", 32'(seq_state), ST_HOLD);
        check("t2_qreq_off", 32'(quiesce_req), 0);
        quiesce_ack = '0;
        wait_cyc(c + 139);
        check("t2_hold_len", 32'(seq_state), ST_HOLD);
        wait_cyc(c + 140);
        check("t2_idle", 32'(seq_state), ST_IDLE);
        push_release(c + 141);
        wait_cyc(c + 205);
        check("t2_ready", 32'(ready), 1);
        check("t2_qto_clear", 32'(qto_err), 0);

        // Link loss with one client never acking: timeout, then reverse assert.
        c = cyc;
        dl_up = 1'b0;
        quiesce_ack = 4'b1011;
        wait_cyc(c + 2);
        check("t3_state_q", 32'(seq_state), ST_QUIESCE);
        push_assert(c + 4098);
        wait_cyc(c + 4097);
        check("t3_qto_early", 32'(qto_err), 0);
        check("t3_still_q", 32'(seq_state), ST_QUIESCE);
        wait_cyc(c + 4098);
        check("t3_qto", 32'(qto_err), 1);
        check("t3_state_as", 32'(seq_state), ST_ASSERT);
        wait_cyc(c + 4230);
        check("t3_idle", 32'(seq_state), ST_IDLE);
        check("t3_qto_sticky", 32'(qto_err), 1);
        check("t3_ready", 32'(ready), 0);
        quiesce_ack = '0;

        // Emergency app_rstn drop mid-release.
        c = cyc;
        dl_up = 1'b1;
        push_ev(c + 18, 4'b0001);
        push_ev(c + 34, 4'b0011);
        wait_cyc(c + 40);
        app_rstn = 1'b0;
        push_ev(c + 41, 4'b0000);
        wait_cyc(c + 41);
        check("t4_state_hold", 32'(seq_state), ST_HOLD);
        check("t4_qreq", 32'(quiesce_req), 0);
        check("t4_ready", 32'(ready), 0);
        wait_cyc(c + 104);
        check("t4_hold_len", 32'(seq_state), ST_HOLD);
        wait_cyc(c + 105);
        check("t4_idle", 32'(seq_state), ST_IDLE);
        wait_cyc(c + 106);
        app_rstn = 1'b1;
        push_release(c + 108);
        wait_cyc(c + 175);
        check("t4_ready", 32'(ready), 1);

        // Asynchronous crst in the middle of a quiesce.
        c = cyc;
        sw_rst_req = 1'b1;
        @(negedge pld_clk);
        sw_rst_req = 1'b0;
        wait_cyc(c + 5);
        check("t6_state_q", 32'(seq_state), ST_QUIESCE);
        check("t6_qreq_on", 32'(quiesce_req), 32'hF);
        push_ev(c + 6, 4'b0000);
        @(posedge pld_clk);
        #2 crst = 1'b1;
        #1;
        check("t6_rstn", 32'(client_rstn), 0);
        check("t6_qreq", 32'(quiesce_req), 0);
        check("t6_ready", 32'(ready), 0);
        check("t6_qto", 32'(qto_err), 0);
        check("t6_state", 32'(seq_state), ST_IDLE);
        dl_up = 1'b0;
        @(negedge pld_clk);
        wait_cyc(cyc + 3);
        crst = 1'b0;
        wait_cyc(cyc + 20);
        check("end_state", 32'(seq_state), ST_IDLE);
        check("end_rstn", 32'(client_rstn), 0);
        check("sb_left", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
